// File: rtl/handshake_fifo_if.sv
// Req/ack handshake bundle for the elastic token buffer: the upstream
// (graph-facing) and downstream (sink-facing) sides.
interface handshake_fifo_if #(
  parameter int unsigned data_width = 32
) ();
  logic                  up_req;
  logic                  up_ack;
  logic [data_width-1:0] up_din;
  logic                  dn_req;
  logic                  dn_ack;
  logic [data_width-1:0] dn_dout;

  // Buffer side: requests tokens upstream, acks the sink downstream.
  modport master (
    output up_req,
    input  up_ack,
    input  up_din,
    input  dn_req,
    output dn_ack,
    output dn_dout
  );

  // Environment side: the upstream producer and the downstream sink.
  modport slave (
    input  up_req,
    output up_ack,
    output up_din,
    output dn_req,
    input  dn_ack,
    input  dn_dout
  );
endinterface

// File: rtl/handshake_fifo.sv
// Elastic token buffer: consumer-style toward a graph output port,
// producer-style toward a sink, with occupancy and token counters.
module handshake_fifo #(
  parameter int unsigned           data_width    = 32,
  parameter int unsigned           depth         = 4,
  parameter logic [data_width-1:0] initial_value = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  handshake_fifo_if.master         hs,
  output logic [$clog2(depth):0]   occupancy_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [31:0]              tokens_in_o,
  output logic [31:0]              tokens_out_o
);
  localparam int unsigned     aw         = $clog2(depth);
  localparam logic [aw:0]     full_level = (aw + 1)'(depth);
  localparam logic [aw:0]     occ_one    = (aw + 1)'(1);
  localparam logic [aw-1:0]   ptr_one    = aw'(1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } up_state_e;

  up_state_e             state_q, state_d;
  logic [data_width-1:0] mem_q [depth];
  logic [aw-1:0]         wr_ptr_q, rd_ptr_q;
  logic [aw:0]           occ_q, occ_d, occ_after_pop;
  logic                  dn_ack_q;
  logic [data_width-1:0] dn_dout_q;
  logic [31:0]           tokens_in_q, tokens_out_q;
  logic                  push, pop, empty;

  assign empty         = (occ_q == '0);
  // An ack only counts while our request is outstanding; others are spurious.
  assign push          = (state_q == ST_WAIT) && hs.up_ack;
  // The ~dn_ack term keeps a sink holding dn_req from being served twice.
  assign pop           = hs.dn_req && !dn_ack_q && !empty;
  assign occ_after_pop = pop ? (occ_q - occ_one) : occ_q;

  // Upstream request FSM: ask whenever a slot is free after this cycle's pop.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (occ_after_pop < full_level) state_d = ST_WAIT;
      ST_WAIT: if (hs.up_ack)                  state_d = ST_IDLE;
      default:                                 state_d = ST_IDLE;
    endcase
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + occ_one;
    else if (pop && !push) occ_d = occ_q - occ_one;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register updates from pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Pointers, occupancy, counters and the registered downstream response.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      tokens_in_q  <= '0;
      tokens_out_q <= '0;
      dn_ack_q     <= 1'b0;
      dn_dout_q    <= initial_value;
    end else begin
      occ_q    <= occ_d;
      dn_ack_q <= pop;
      if (push) begin
        wr_ptr_q    <= wr_ptr_q + ptr_one;
        tokens_in_q <= tokens_in_q + 32'd1;
      end
      if (pop) begin
        dn_dout_q    <= mem_q[rd_ptr_q];
        rd_ptr_q     <= rd_ptr_q + ptr_one;
        tokens_out_q <= tokens_out_q + 32'd1;
      end
    end
  end

  // Token storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; pointers and occupancy say which words are valid.
    if (push && !rst) mem_q[wr_ptr_q] <= hs.up_din;
  end

  assign hs.up_req    = (state_q == ST_WAIT);
  assign hs.dn_ack    = dn_ack_q;
  assign hs.dn_dout   = dn_dout_q;
  assign occupancy_o  = occ_q;
  assign full_o       = (occ_q == full_level);
  assign empty_o      = empty;
  assign tokens_in_o  = tokens_in_q;
  assign tokens_out_o = tokens_out_q;
endmodule

// File: doc/handshake_fifo.md
# handshake_fifo

Elastic token buffer for the req/ack dataflow fabric. It sits directly downstream of a graph block's `dout_req`/`dout_ack`/`dout` output port and upstream of a consumer. Toward the graph it behaves like a consumer: it holds a level request and takes data on a one-cycle ack pulse. Toward the sink it behaves like a producer: on the sink's request it answers with a one-cycle ack pulse and data. It decouples sink stalls from the operator graph and exposes occupancy and token counters for throughput measurement.

## Interface
- `data_width`, 32: token width in bits.
- `depth`, 4: buffer slots; must be a power of two and at least 2. `aw = clog2(depth)`.
- `initial_value`, 0: value driven on `dn_dout` after reset.

- `clk`, in, 1: single clock; all logic on `posedge clk`.
- `rst`, in, 1: synchronous, active-high reset.
- `up_req`, out, 1: request to the upstream block (a graph output port).
- `up_ack`, in, 1: one-cycle ack from upstream; `up_din` is valid in the same cycle.
- `up_din`, in, `data_width`: upstream data.
- `dn_req`, in, 1: level request from the sink.
- `dn_ack`, out, 1: one-cycle ack to the sink; `dn_dout` is valid in the same cycle.
- `dn_dout`, out, `data_width`: token delivered to the sink.
- `occupancy`, out, `aw+1`: number of stored tokens.
- `full`, out, 1: `occupancy == depth`.
- `empty`, out, 1: `occupancy == 0`.
- `tokens_in`, out, 32: accepted-token count; wraps modulo 2^32.
- `tokens_out`, out, 32: delivered-token count; wraps modulo 2^32.

## Operation
- Storage is `depth` words with `wr_ptr` and `rd_ptr`, each `aw` bits. Both pointers wrap naturally modulo `depth`.
- Upstream side is a two-state FSM:
  - IDLE (`up_req=0`): go to WAIT and set `up_req<=1` when `occupancy < depth` after this cycle's pop. A pop in the same cycle frees the slot.
  - WAIT (`up_req=1`): on `up_ack`, write `up_din` to `mem[wr_ptr]`, increment `wr_ptr` and `tokens_in`, set `up_req<=0`, and return to IDLE.
  - At most one request is outstanding at a time.
- `up_ack` sampled while `up_req=0` is spurious: it is ignored, with no write and no counter change.
- Downstream side is a registered, producer-style responder:
  - Default `dn_ack<=0` every cycle.
  - If `dn_req & ~dn_ack & ~empty`: `dn_ack<=1`, `dn_dout<=mem[rd_ptr]`, increment `rd_ptr` and `tokens_out`.
  - The `~dn_ack` term forbids back-to-back acks, so a sink that holds `dn_req` through an ack cycle is not double-served.
- Occupancy:
  - Push only: +1. Pop only: −1. Push and pop in the same cycle: unchanged.
  - A push never happens at full, because `up_req` is only raised with a free slot. A pop never happens at empty.
- `dn_dout` holds its last delivered value between acks.
- Data ordering is strict FIFO, with no loss and no duplication.

## Timing
- Reset values: `up_req=0`, `dn_ack=0`, `dn_dout=initial_value`, `occupancy=0`, `full=0`, `empty=1`, `tokens_in=0`, `tokens_out=0`, both pointers 0, FSM in IDLE.
- Reset applied mid-operation discards all stored tokens and any outstanding request. An `up_ack` arriving in the reset cycle is dropped.
- First `up_req` rises at the first clock edge after `rst` deasserts.
- Write latency: a token acked at edge E is counted in `occupancy` after E.
- The earliest `dn_ack` for that token is at edge E+1, provided `dn_req=1` and the FIFO was empty before E.
- Upstream re-request: `up_req` falls at the ack edge E and can rise again at E+1. The upstream token rate is therefore at most one per three cycles against a producer-style source.
- Downstream rate: at most one token every two cycles.
- `full`, `empty`, and `occupancy` reflect the same register state. All three are combinational from the occupancy register.

## Test plan
- **Streaming order:** producer emits 0,1,2,…; sink holds `dn_req=1`; `depth=4`. Required: the sink receives 0..99 in order, and `tokens_in - tokens_out` never exceeds 4.
- **Stall to full:** `dn_req=0` while the producer supplies 0,1,2,3. Required: `occupancy=4` and `full=1`, and `up_req` stays 0 for 20 cycles. After `dn_req=1`, four acks deliver 0,1,2,3 and `up_req` rises again once the first slot frees.
- **Simultaneous push/pop:** at `occupancy=2`, `up_ack` (with `up_req=1`) and a pop happen on the same edge. Required: `occupancy` stays 2 and the order is preserved.
- **Empty:** `dn_req=1` with `occupancy=0`. Required: `dn_ack` stays 0 for 10 cycles and `dn_dout` holds the last value, or `initial_value` if nothing has been delivered.
- **Mid-operation reset:** at `occupancy=3` with `up_req=1`, assert `rst` for one cycle. Required: all outputs take their reset values on the next edge. After reset the first delivered token is the next producer value, not a stale one.
- **Spurious ack:** pulse `up_ack` while `up_req=0` with `up_din=0xDEAD`. Required: `tokens_in` and `occupancy` are unchanged, and `0xDEAD` is never delivered.
